// File: rtl/cdec_run_ctrl.sv
// Run/step sequencer for the CDEC core: gates the core clock enable from monitor commands,
// stops on breakpoint or halt, and hands the memory port to the monitor only while stopped.
module cdec_run_ctrl #(
   parameter int PC_W   = 8,
   parameter int STEP_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              cpu_halt,
   input  logic [PC_W-1:0]   cpu_pc,
   output logic              cpu_en,
   input  logic              mem_req,
   output logic              mem_gnt,
   output logic [1:0]        state,
   output logic              bp_hit,
   output logic              halted,
   output logic [STEP_W-1:0] steps_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_GNT  = 2'b11
   } state_t;

   localparam logic [2:0] OP_STOP  = 3'b000;
   localparam logic [2:0] OP_RUN   = 3'b001;
   localparam logic [2:0] OP_STEP  = 3'b010;
   localparam logic [2:0] OP_SETBP = 3'b011;
   localparam logic [2:0] OP_CLRBP = 3'b100;

   state_t            r_state;
   state_t            w_stateNext;
   logic              r_bpEn;
   logic [PC_W-1:0]   r_bpAddr;
   logic [STEP_W-1:0] r_remaining;
   logic [STEP_W-1:0] r_stepsDone;
   logic              r_bpHit;
   logic              r_halted;
   logic              r_first;

   logic w_active;
   logic w_cmdReady;
   logic w_accept;
   logic w_bpMatch;
   logic w_cpuEn;
   logic w_startRun;
   logic w_loadSteps;

   // r_first masks the breakpoint for one cycle so a resume from the breakpoint PC makes progress
   assign w_active   = (r_state == S_RUN) || (r_state == S_STEP);
   assign w_cmdReady = (r_state != S_GNT) && !((r_state == S_IDLE) && mem_req);
   assign w_accept   = cmd_valid && w_cmdReady;
   assign w_bpMatch  = r_bpEn && (cpu_pc == r_bpAddr) && !r_first;
   assign w_cpuEn    = w_active && !cpu_halt && !w_bpMatch;

   always_comb begin
      w_stateNext = r_state;
      w_startRun  = 1'b0;
      w_loadSteps = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_req) begin
               w_stateNext = S_GNT;
            end else if (w_accept && (cmd_op == OP_RUN)) begin
               w_stateNext = S_RUN;
               w_startRun  = 1'b1;
            end else if (w_accept && (cmd_op == OP_STEP)) begin
               w_startRun  = 1'b1;
               w_loadSteps = 1'b1;
               if (cmd_arg != '0) begin
                  w_stateNext = S_STEP;
               end
            end
         end
         S_RUN, S_STEP: begin
            if (cpu_halt || w_bpMatch || (w_accept && (cmd_op == OP_STOP)) ||
                ((r_state == S_STEP) && w_cpuEn && (r_remaining == STEP_W'(1)))) begin
               w_stateNext = S_IDLE;
            end
         end
         S_GNT: begin
            if (!mem_req) begin
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bpEn      <= 1'b0;
         r_bpAddr    <= '0;
         r_remaining <= '0;
         r_stepsDone <= '0;
         r_bpHit     <= 1'b0;
         r_halted    <= 1'b0;
         r_first     <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_accept && (cmd_op == OP_SETBP)) begin
            r_bpEn   <= 1'b1;
            r_bpAddr <= cmd_arg[PC_W-1:0];
         end else if (w_accept && (cmd_op == OP_CLRBP)) begin
            r_bpEn <= 1'b0;
         end
         if (w_startRun) begin
            r_bpHit     <= 1'b0;
            r_halted    <= 1'b0;
            r_stepsDone <= '0;
            r_first     <= 1'b1;
            if (w_loadSteps) begin
               r_remaining <= cmd_arg;
            end
         end else if (w_active) begin
            r_first <= 1'b0;
            if (cpu_halt) begin
               r_halted <= 1'b1;
            end
            if (w_bpMatch) begin
               r_bpHit <= 1'b1;
            end
            if (w_cpuEn) begin
               if (r_state == S_STEP) begin
                  r_remaining <= r_remaining - STEP_W'(1);
               end
               if (r_stepsDone != '1) begin
                  r_stepsDone <= r_stepsDone + STEP_W'(1);
               end
            end
         end
      end
   end

   assign cmd_ready  = w_cmdReady;
   assign cpu_en     = w_cpuEn;
   assign mem_gnt    = (r_state == S_GNT);
   assign state      = r_state;
   assign bp_hit     = r_bpHit;
   assign halted     = r_halted;
   assign steps_done = r_stepsDone;

endmodule
